// File: rtl/seq_divider_restoring_if.sv
// Operand/result bundle between a requester and the restoring divider.
// The requester drives start and operands; the divider returns status and results.
interface seq_divider_restoring_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider_restoring.sv
// Iterative unsigned restoring divider: one quotient bit per clock, single-cycle done pulse.
// Results hold until the next completed division; divide-by-zero skips the iteration phase.
module seq_divider_restoring #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  seq_divider_restoring_if.slave bus
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state,    w_state_n;
  logic [WIDTH-1:0] r_a,        w_a_n;
  logic [WIDTH-1:0] r_b,        w_b_n;
  logic [WIDTH:0]   r_acc,      w_acc_n;
  logic [WIDTH-1:0] r_sh,       w_sh_n;
  logic [CW-1:0]    r_cnt,      w_cnt_n;
  logic             r_dbz_pend, w_dbz_pend_n;
  logic [WIDTH-1:0] r_quot,     w_quot_n;
  logic [WIDTH-1:0] r_rem,      w_rem_n;
  logic             r_dbz,      w_dbz_n;
  logic             r_busy,     w_busy_n;
  logic             r_done,     w_done_n;

  logic [WIDTH:0]   w_trial;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic             w_unused_acc_msb;

  // Trial subtract on the shifted partial remainder; WIDTH+1 bits so it cannot overflow.
  assign w_trial          = {r_acc[WIDTH-1:0], r_sh[WIDTH-1]};
  assign w_diff           = w_trial - {1'b0, r_b};
  assign w_ge             = (w_trial >= {1'b0, r_b});
  assign w_unused_acc_msb = r_acc[WIDTH];

  // Next-state and datapath update.
  always_comb begin
    w_state_n    = r_state;
    w_a_n        = r_a;
    w_b_n        = r_b;
    w_acc_n      = r_acc;
    w_sh_n       = r_sh;
    w_cnt_n      = r_cnt;
    w_dbz_pend_n = r_dbz_pend;
    w_quot_n     = r_quot;
    w_rem_n      = r_rem;
    w_dbz_n      = r_dbz;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_a_n   = bus.dividend;
          w_b_n   = bus.divisor;
          w_acc_n = '0;
          w_sh_n  = bus.dividend;
          w_cnt_n = CW'(WIDTH - 1);
          if (bus.divisor != '0) begin
            w_state_n    = S_CALC;
            w_dbz_pend_n = 1'b0;
          end else begin
            w_state_n    = S_DONE;
            w_dbz_pend_n = 1'b1;
          end
        end
      end

      S_CALC: begin
        w_sh_n  = {r_sh[WIDTH-2:0], w_ge};
        w_acc_n = w_ge ? w_diff : w_trial;
        if (r_cnt == '0) begin
          w_state_n = S_DONE;
        end else begin
          w_cnt_n = r_cnt - CW'(1);
        end
      end

      S_DONE: begin
        w_state_n = S_IDLE;
        w_quot_n  = r_dbz_pend ? '1  : r_sh;
        w_rem_n   = r_dbz_pend ? r_a : r_acc[WIDTH-1:0];
        w_dbz_n   = r_dbz_pend;
      end

      default: begin
        w_state_n = S_IDLE;
      end
    endcase

    w_busy_n = (r_state != S_IDLE);
    w_done_n = (r_state == S_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_acc      <= '0;
      r_sh       <= '0;
      r_cnt      <= '0;
      r_dbz_pend <= 1'b0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_dbz      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_a        <= w_a_n;
      r_b        <= w_b_n;
      r_acc      <= w_acc_n;
      r_sh       <= w_sh_n;
      r_cnt      <= w_cnt_n;
      r_dbz_pend <= w_dbz_pend_n;
      r_quot     <= w_quot_n;
      r_rem      <= w_rem_n;
      r_dbz      <= w_dbz_n;
      r_busy     <= w_busy_n;
      r_done     <= w_done_n;
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_rem;
  assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider_restoring.sv
// Directed bench for seq_divider_restoring at WIDTH=4.
module tb_seq_divider_restoring;

  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  seq_divider_restoring_if #(.WIDTH(W)) bus ();

  seq_divider_restoring #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Issue one division and wait for done; lat counts negedges after the accept edge (0 = timeout).
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic dbz, output int lat, output int busy_cyc);
    lat = 0; busy_cyc = 0; q = '0; r = '0; dbz = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bus.busy) busy_cyc++;
      if (bus.done) begin
        lat = n; q = bus.quotient; r = bus.remainder; dbz = bus.div_by_zero;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    total++; if (bus.quotient !== 4'd0) begin bad++; $display("FAIL reset_q got=%0d exp=0", bus.quotient); end
    total++; if (bus.remainder !== 4'd0) begin bad++; $display("FAIL reset_r got=%0d exp=0", bus.remainder); end
    total++; if (bus.div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz got=%b exp=0", bus.div_by_zero); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [W-1:0] q, r; logic dbz; int lat, bc;
    run_div(4'd13, 4'd3, q, r, dbz, lat, bc);
    total++; if (lat != 6) begin bad++; $display("FAIL basic_latency got=%0d exp=6", lat); end
    total++; if (q !== 4'd4) begin bad++; $display("FAIL basic_q got=%0d exp=4", q); end
    total++; if (r !== 4'd1) begin bad++; $display("FAIL basic_r got=%0d exp=1", r); end
    total++; if (dbz !== 1'b0) begin bad++; $display("FAIL basic_dbz got=%b exp=0", dbz); end
    total++; if (bc != 5) begin bad++; $display("FAIL basic_busy_cycles got=%0d exp=5", bc); end
    // Results must hold while idle, regardless of operand wiggling without start.
    bus.dividend = 4'd0; bus.divisor = 4'd9;
    repeat (3) @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL hold_busy got=%b exp=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL hold_done got=%b exp=0", bus.done); end
    total++; if (bus.quotient !== 4'd4) begin bad++; $display("FAIL hold_q got=%0d exp=4", bus.quotient); end
    total++; if (bus.remainder !== 4'd1) begin bad++; $display("FAIL hold_r got=%0d exp=1", bus.remainder); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] q, r; logic dbz; int lat, bc;
    run_div(4'd15, 4'd1, q, r, dbz, lat, bc);
    total++; if (lat != 6) begin bad++; $display("FAIL b2b1_latency got=%0d exp=6", lat); end
    total++; if (q !== 4'd15) begin bad++; $display("FAIL b2b1_q got=%0d exp=15", q); end
    total++; if (r !== 4'd0) begin bad++; $display("FAIL b2b1_r got=%0d exp=0", r); end
    run_div(4'd2, 4'd7, q, r, dbz, lat, bc);
    total++; if (lat != 6) begin bad++; $display("FAIL b2b2_latency got=%0d exp=6", lat); end
    total++; if (q !== 4'd0) begin bad++; $display("FAIL b2b2_q got=%0d exp=0", q); end
    total++; if (r !== 4'd2) begin bad++; $display("FAIL b2b2_r got=%0d exp=2", r); end
  endtask

  task automatic test_div_by_zero();
    logic [W-1:0] q, r; logic dbz; int lat, bc;
    run_div(4'd5, 4'd0, q, r, dbz, lat, bc);
    total++; if (lat != 2) begin bad++; $display("FAIL dbz_latency got=%0d exp=2", lat); end
    total++; if (q !== 4'hF) begin bad++; $display("FAIL dbz_q got=%0h exp=f", q); end
    total++; if (r !== 4'd5) begin bad++; $display("FAIL dbz_r got=%0d exp=5", r); end
    total++; if (dbz !== 1'b1) begin bad++; $display("FAIL dbz_flag got=%b exp=1", dbz); end
    total++; if (bc != 1) begin bad++; $display("FAIL dbz_busy_cycles got=%0d exp=1", bc); end
    run_div(4'd9, 4'd4, q, r, dbz, lat, bc);
    total++; if (q !== 4'd2) begin bad++; $display("FAIL dbz_next_q got=%0d exp=2", q); end
    total++; if (r !== 4'd1) begin bad++; $display("FAIL dbz_next_r got=%0d exp=1", r); end
    total++; if (dbz !== 1'b0) begin bad++; $display("FAIL dbz_next_flag got=%b exp=0", dbz); end
  endtask

  task automatic test_start_ignored();
    int first = 0; int dcnt = 0;
    logic [W-1:0] q = '0, r = '0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.dividend = 4'd12; bus.divisor = 4'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 2) begin bus.start = 1'b1; bus.dividend = 4'd1; bus.divisor = 4'd1; end
      if (n == 3) begin bus.start = 1'b0; bus.dividend = 4'd0; bus.divisor = 4'd0; end
      if (bus.done) begin
        dcnt++;
        if (first == 0) begin first = n; q = bus.quotient; r = bus.remainder; end
      end
    end
    total++; if (dcnt != 1) begin bad++; $display("FAIL ignore_done_count got=%0d exp=1", dcnt); end
    total++; if (first != 6) begin bad++; $display("FAIL ignore_latency got=%0d exp=6", first); end
    total++; if (q !== 4'd2) begin bad++; $display("FAIL ignore_q got=%0d exp=2", q); end
    total++; if (r !== 4'd2) begin bad++; $display("FAIL ignore_r got=%0d exp=2", r); end
  endtask

  task automatic test_reset_mid_calc();
    logic [W-1:0] q, r; logic dbz; int lat, bc;
    int dcnt = 0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.dividend = 4'd11; bus.divisor = 4'd2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      if (bus.done) dcnt++;
      if (n == 3) rst = 1'b1;
      if (n == 4) begin
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstcalc_busy got=%b exp=0", bus.busy); end
        total++; if (bus.quotient !== 4'd0) begin bad++; $display("FAIL rstcalc_q got=%0d exp=0", bus.quotient); end
        total++; if (bus.remainder !== 4'd0) begin bad++; $display("FAIL rstcalc_r got=%0d exp=0", bus.remainder); end
        rst = 1'b0;
      end
    end
    total++; if (dcnt != 0) begin bad++; $display("FAIL rstcalc_done_count got=%0d exp=0", dcnt); end
    run_div(4'd7, 4'd7, q, r, dbz, lat, bc);
    total++; if (lat != 6) begin bad++; $display("FAIL rstcalc_next_latency got=%0d exp=6", lat); end
    total++; if (q !== 4'd1) begin bad++; $display("FAIL rstcalc_next_q got=%0d exp=1", q); end
    total++; if (r !== 4'd0) begin bad++; $display("FAIL rstcalc_next_r got=%0d exp=0", r); end
  endtask

  task automatic test_exhaustive();
    logic [W-1:0] q, r; logic dbz; int lat, bc;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_div(W'(a), W'(b), q, r, dbz, lat, bc);
        total++;
        if (lat == 0) begin
          bad++; $display("FAIL exh_timeout a=%0d b=%0d got=no_done exp=done", a, b);
        end else if (b != 0) begin
          if ((int'(q) * b + int'(r)) != a || int'(r) >= b || dbz !== 1'b0) begin
            bad++;
            $display("FAIL exh a=%0d b=%0d got q=%0d r=%0d dbz=%b exp q=%0d r=%0d dbz=0",
                     a, b, q, r, dbz, a / b, a % b);
          end
        end else begin
          if (dbz !== 1'b1 || q !== 4'hF || int'(r) != a) begin
            bad++;
            $display("FAIL exh_dbz a=%0d got q=%0h r=%0d dbz=%b exp q=f r=%0d dbz=1", a, q, r, dbz, a);
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_by_zero();
    test_start_ignored();
    test_reset_mid_calc();
    test_exhaustive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
